// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
  parameter int DM_ADDR_W = 14
);
  logic                 dm_req;
  logic [3:0]           dm_we;
  logic [DM_ADDR_W-1:0] dm_addr;
  logic [31:0]          dm_wdata;
  logic [31:0]          dm_rdata;
  logic                 dm_ready;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ready
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ready
  );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: drives the data-memory port, shapes store lanes,
// extracts/extends load data, stalls on slow memory, holds MEM/WB register.
module mem_stage #(
  parameter int DM_ADDR_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_Memread,
  input  logic               MEM_Memwrite,
  input  logic               MEM_Memtoreg,
  input  logic               MEM_Regwrite,
  input  logic               MEM_RDsrc,
  input  logic [31:0]        MEM_pc_to_reg,
  input  logic [31:0]        MEM_alu_out,
  input  logic [31:0]        MEM_forward_rs2_data,
  input  logic [4:0]         MEM_rd_addr,
  input  logic [2:0]         MEM_funct3,
  mem_stage_if.master        dm,
  output logic               mem_stall,
  output logic [31:0]        MEM_fwd_data,
  output logic               misalign_err,
  output logic               WB_Regwrite,
  output logic [4:0]         WB_rd_addr,
  output logic [31:0]        WB_rd_data
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0] wb_rd_data_q, wb_rd_data_d;
  logic        misalign_err_q, misalign_err_d;

  logic        mem_op_s;
  logic        misalign_s;
  logic        access_s;
  logic [1:0]  byte_off_s;
  logic [31:0] src_data_s;
  logic [31:0] load_shift_s;
  logic [31:0] load_data_s;
  logic        dm_req_s;
  logic        mem_stall_s;

  // Decode access type, alignment, source data and load extraction.
  always_comb begin
    mem_op_s     = MEM_Memread | MEM_Memwrite;
    byte_off_s   = MEM_alu_out[1:0];
    misalign_s   = ((MEM_funct3[1:0] == 2'b01) && byte_off_s[0]) ||
                   ((MEM_funct3[1:0] == 2'b10) && (byte_off_s != 2'b00));
    access_s     = mem_op_s & ~misalign_s;
    src_data_s   = MEM_RDsrc ? MEM_pc_to_reg : MEM_alu_out;
    load_shift_s = dm.dm_rdata >> {byte_off_s, 3'b000};
    case (MEM_funct3)
      3'b000:  load_data_s = {{24{load_shift_s[7]}}, load_shift_s[7:0]};
      3'b001:  load_data_s = {{16{load_shift_s[15]}}, load_shift_s[15:0]};
      3'b100:  load_data_s = {24'h000000, load_shift_s[7:0]};
      3'b101:  load_data_s = {16'h0000, load_shift_s[15:0]};
      default: load_data_s = dm.dm_rdata;
    endcase
  end

  // State register: reset aborts any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter WAIT when memory does not answer in the request cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (access_s && !dm.dm_ready) state_d = S_WAIT;
        else                          state_d = S_IDLE;
      end
      S_WAIT: begin
        if (dm.dm_ready) state_d = S_IDLE;
        else             state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request and stall; both forced low while reset is held.
  always_comb begin
    dm_req_s    = 1'b0;
    mem_stall_s = 1'b0;
    if (rst) begin
      dm_req_s    = 1'b0;
      mem_stall_s = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dm_req_s    = access_s;
          mem_stall_s = access_s & ~dm.dm_ready;
        end
        S_WAIT: begin
          dm_req_s    = 1'b1;
          mem_stall_s = ~dm.dm_ready;
        end
        default: begin
          dm_req_s    = 1'b0;
          mem_stall_s = 1'b0;
        end
      endcase
    end
  end

  // Memory port: word address, lane-replicated data, shifted byte enables.
  always_comb begin
    dm.dm_req  = dm_req_s;
    dm.dm_addr = MEM_alu_out[DM_ADDR_W+1:2];
    case (MEM_funct3)
      3'b000:  dm.dm_wdata = {4{MEM_forward_rs2_data[7:0]}};
      3'b001:  dm.dm_wdata = {2{MEM_forward_rs2_data[15:0]}};
      default: dm.dm_wdata = MEM_forward_rs2_data;
    endcase
    if (dm_req_s && MEM_Memwrite) begin
      case (MEM_funct3)
        3'b000:  dm.dm_we = 4'b0001 << byte_off_s;
        3'b001:  dm.dm_we = 4'b0011 << byte_off_s;
        default: dm.dm_we = 4'b1111;
      endcase
    end else begin
      dm.dm_we = 4'b0000;
    end
  end

  // MEM/WB next values: bubble on stall or suppressed misaligned access.
  always_comb begin
    wb_regwrite_d  = wb_regwrite_q;
    wb_rd_addr_d   = wb_rd_addr_q;
    wb_rd_data_d   = wb_rd_data_q;
    misalign_err_d = mem_op_s & misalign_s;
    if (mem_stall_s) begin
      wb_regwrite_d = 1'b0;
    end else if (mem_op_s && misalign_s) begin
      wb_regwrite_d = 1'b0;
    end else begin
      wb_regwrite_d = MEM_Regwrite;
      wb_rd_addr_d  = MEM_rd_addr;
      wb_rd_data_d  = MEM_Memtoreg ? load_data_s : src_data_s;
    end
  end

  // MEM/WB pipeline register and misalignment pulse flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_regwrite_q  <= 1'b0;
      wb_rd_addr_q   <= 5'd0;
      wb_rd_data_q   <= 32'd0;
      misalign_err_q <= 1'b0;
    end else begin
      wb_regwrite_q  <= wb_regwrite_d;
      wb_rd_addr_q   <= wb_rd_addr_d;
      wb_rd_data_q   <= wb_rd_data_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign mem_stall    = mem_stall_s;
  assign MEM_fwd_data = src_data_s;
  assign misalign_err = misalign_err_q;
  assign WB_Regwrite  = wb_regwrite_q;
  assign WB_rd_addr   = wb_rd_addr_q;
  assign WB_rd_data   = wb_rd_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected WB writes,
// a monitor pops and compares whenever WB_Regwrite is seen.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_Memread = 1'b0, MEM_Memwrite = 1'b0, MEM_Memtoreg = 1'b0;
  logic        MEM_Regwrite = 1'b0, MEM_RDsrc = 1'b0;
  logic [31:0] MEM_pc_to_reg = 32'd0, MEM_alu_out = 32'd0, MEM_forward_rs2_data = 32'd0;
  logic [4:0]  MEM_rd_addr = 5'd0;
  logic [2:0]  MEM_funct3 = 3'd0;
  logic        mem_stall, misalign_err, WB_Regwrite;
  logic [31:0] MEM_fwd_data, WB_rd_data;
  logic [4:0]  WB_rd_addr;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  mem_stage_if #(.DM_ADDR_W(14)) dmi ();

  mem_stage #(.DM_ADDR_W(14)) dut (
    .clk(clk), .rst(rst),
    .MEM_Memread(MEM_Memread), .MEM_Memwrite(MEM_Memwrite),
    .MEM_Memtoreg(MEM_Memtoreg), .MEM_Regwrite(MEM_Regwrite),
    .MEM_RDsrc(MEM_RDsrc), .MEM_pc_to_reg(MEM_pc_to_reg),
    .MEM_alu_out(MEM_alu_out), .MEM_forward_rs2_data(MEM_forward_rs2_data),
    .MEM_rd_addr(MEM_rd_addr), .MEM_funct3(MEM_funct3),
    .dm(dmi),
    .mem_stall(mem_stall), .MEM_fwd_data(MEM_fwd_data),
    .misalign_err(misalign_err), .WB_Regwrite(WB_Regwrite),
    .WB_rd_addr(WB_rd_addr), .WB_rd_data(WB_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic m2r,
                       input logic rw, input logic rsrc, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3);
    MEM_Memread = rd_en; MEM_Memwrite = wr_en; MEM_Memtoreg = m2r;
    MEM_Regwrite = rw; MEM_RDsrc = rsrc; MEM_pc_to_reg = pc;
    MEM_alu_out = alu; MEM_forward_rs2_data = rs2; MEM_rd_addr = rd;
    MEM_funct3 = f3;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 3'b000);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every WB write must match the oldest expected entry.
  always @(posedge clk) begin
    #2;
    if (!rst && WB_Regwrite) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected_write", {27'd0, WB_rd_addr}, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd_addr", {27'd0, WB_rd_addr}, {27'd0, e.rd});
        chk("wb_rd_data", WB_rd_data, e.data);
      end
    end
  end

  initial begin
    dmi.dm_ready = 1'b1;
    dmi.dm_rdata = 32'd0;
    #1;
    chk("reset_wb_regwrite", {31'd0, WB_Regwrite}, 32'd0);
    chk("reset_wb_rd_data", WB_rd_data, 32'd0);
    chk("reset_misalign", {31'd0, misalign_err}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // ALU op with PC source and ALU source
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 32'hDEAD, 32'd0, 5'd1, 3'b000);
    #1;
    chk("alu_pc_dm_req", {31'd0, dmi.dm_req}, 32'd0);
    chk("alu_pc_fwd", MEM_fwd_data, 32'h104);
    push(5'd1, 32'h104);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h104, 32'h55AA, 32'd0, 5'd2, 3'b000);
    #1;
    chk("alu_src_fwd", MEM_fwd_data, 32'h55AA);
    push(5'd2, 32'h55AA);
    step();

    // Stores: byte, half, word
    dmi.dm_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1002, 32'h000000A5, 5'd0, 3'b000);
    #1;
    chk("sb_req", {31'd0, dmi.dm_req}, 32'd1);
    chk("sb_we", {28'd0, dmi.dm_we}, 32'h4);
    chk("sb_wdata", dmi.dm_wdata, 32'hA5A5A5A5);
    chk("sb_addr", {18'd0, dmi.dm_addr}, 32'h400);
    chk("sb_stall", {31'd0, mem_stall}, 32'd0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h2, 32'h1234BEEF, 5'd0, 3'b001);
    #1;
    chk("sh_we", {28'd0, dmi.dm_we}, 32'hC);
    chk("sh_wdata", dmi.dm_wdata, 32'hBEEFBEEF);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h8, 32'hCAFEF00D, 5'd0, 3'b010);
    #1;
    chk("sw_we", {28'd0, dmi.dm_we}, 32'hF);
    chk("sw_wdata", dmi.dm_wdata, 32'hCAFEF00D);
    chk("sw_addr", {18'd0, dmi.dm_addr}, 32'h2);
    step();

    // Loads with zero-wait memory
    dmi.dm_rdata = 32'h80FF1234;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h3, 32'd0, 5'd7, 3'b000);
    #1;
    chk("lb_we", {28'd0, dmi.dm_we}, 32'd0);
    chk("lb_req", {31'd0, dmi.dm_req}, 32'd1);
    push(5'd7, 32'hFFFFFF80);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h2, 32'd0, 5'd8, 3'b101);
    push(5'd8, 32'h000080FF);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h0, 32'd0, 5'd9, 3'b001);
    push(5'd9, 32'h00001234);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h2, 32'd0, 5'd10, 3'b100);
    push(5'd10, 32'h000000FF);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h4, 32'd0, 5'd11, 3'b010);
    push(5'd11, 32'h80FF1234);
    step();

    // LW with three wait cycles
    dmi.dm_rdata = 32'h13579BDF;
    dmi.dm_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h20, 32'd0, 5'd12, 3'b010);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_stall", {31'd0, mem_stall}, 32'd1);
      chk("wait_req", {31'd0, dmi.dm_req}, 32'd1);
      step();
      chk("wait_wb_bubble", {31'd0, WB_Regwrite}, 32'd0);
    end
    dmi.dm_ready = 1'b1;
    #1;
    chk("wait_done_stall", {31'd0, mem_stall}, 32'd0);
    push(5'd12, 32'h13579BDF);
    step();
    nop();
    step();
    step();

    // Misaligned accesses
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h6, 32'd0, 5'd13, 3'b010);
    #1;
    chk("mis_lw_req", {31'd0, dmi.dm_req}, 32'd0);
    chk("mis_lw_stall", {31'd0, mem_stall}, 32'd0);
    chk("mis_lw_err_pre", {31'd0, misalign_err}, 32'd0);
    step();
    chk("mis_lw_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_lw_wb", {31'd0, WB_Regwrite}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1, 32'h1111, 5'd0, 3'b001);
    #1;
    chk("mis_sh_req", {31'd0, dmi.dm_req}, 32'd0);
    chk("mis_sh_we", {28'd0, dmi.dm_we}, 32'd0);
    step();
    nop();
    step();
    chk("mis_err_clear", {31'd0, misalign_err}, 32'd0);

    // Reset mid-WAIT
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1234, 32'd0, 5'd3, 3'b000);
    push(5'd3, 32'h1234);
    step();
    dmi.dm_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h10, 32'd0, 5'd4, 3'b010);
    step();
    #1;
    chk("pre_rst_stall", {31'd0, mem_stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_req", {31'd0, dmi.dm_req}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_wb_regwrite", {31'd0, WB_Regwrite}, 32'd0);
    chk("rst_wb_data", WB_rd_data, 32'd0);
    nop();
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_idle_req", {31'd0, dmi.dm_req}, 32'd0);
    dmi.dm_ready = 1'b1;
    step();
    step();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
